// File: rtl/cpu_tlb_refill_ctrl_if.sv
// Memory read port between the TLB refill controller (master) and the memory/cache (slave).
interface cpu_tlb_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_tlb_refill_ctrl.sv
// Shared I/D TLB miss handler: arbitrates misses, reads one PTE, refills the owner TLB or faults.
// Defining CPU_TLB_WALK_TIMEOUT_EN adds a walk timeout that faults after TIMEOUT cycles in REQ/WAIT.
module cpu_tlb_refill_ctrl #(
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   itlb_miss,
  input  logic [KEY_WIDTH-1:0]   itlb_key,
  input  logic                   dtlb_miss,
  input  logic [KEY_WIDTH-1:0]   dtlb_key,
  input  logic [ADDR_WIDTH-1:0]  ptbr,
  cpu_tlb_refill_ctrl_if.master  mem,
  output logic                   itlb_write,
  output logic                   dtlb_write,
  output logic [KEY_WIDTH-1:0]   tlb_key,
  output logic [VALUE_WIDTH-1:0] tlb_value,
  output logic                   fault_i,
  output logic                   fault_d,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic                   holdoff_q, holdoff_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   itlb_write_q, itlb_write_d;
  logic                   dtlb_write_q, dtlb_write_d;
  logic [KEY_WIDTH-1:0]   tlb_key_q, tlb_key_d;
  logic [VALUE_WIDTH-1:0] tlb_value_q, tlb_value_d;
  logic                   fault_i_q, fault_i_d;
  logic                   fault_d_q, fault_d_d;
  logic                   busy_q, busy_d;
  logic                   grant_d;
  logic                   walk_timeout;
  logic                   unused_pte_bits;

  assign unused_pte_bits = ^mem.mem_rdata[DATA_WIDTH-2:VALUE_WIDTH];

`ifdef CPU_TLB_WALK_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero on entry to REQ and counts every REQ/WAIT cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_REQ || state_q == S_WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign walk_timeout = (state_q == S_REQ || state_q == S_WAIT) &&
                        (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign walk_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    holdoff_d    = 1'b0;
    key_d        = key_q;
    grant_d      = OWN_I;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    itlb_write_d = 1'b0;
    dtlb_write_d = 1'b0;
    tlb_key_d    = tlb_key_q;
    tlb_value_d  = tlb_value_q;
    fault_i_d    = 1'b0;
    fault_d_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // holdoff_q masks the miss lines while the refilled TLB settles.
        if (!holdoff_q && (itlb_miss || dtlb_miss)) begin
          grant_d      = dtlb_miss && (!itlb_miss || last_grant_q == OWN_I);
          owner_d      = grant_d;
          last_grant_d = grant_d;
          key_d        = grant_d ? dtlb_key : itlb_key;
          mem_req_d    = 1'b1;
          mem_addr_d   = ptbr + (ADDR_WIDTH'(key_d) << 2);
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.mem_ready) state_d   = S_WAIT;
        else               mem_req_d = 1'b1;
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = S_FILL;
          if (mem.mem_rdata[DATA_WIDTH-1]) begin
            itlb_write_d = (owner_q == OWN_I);
            dtlb_write_d = (owner_q == OWN_D);
            tlb_key_d    = key_q;
            tlb_value_d  = mem.mem_rdata[VALUE_WIDTH-1:0];
          end else begin
            fault_i_d = (owner_q == OWN_I);
            fault_d_d = (owner_q == OWN_D);
          end
        end
      end
      S_FILL: begin
        state_d   = S_IDLE;
        holdoff_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A response arriving on the last allowed cycle still wins over the timeout.
    if (walk_timeout && state_d != S_FILL) begin
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
      fault_i_d = (owner_q == OWN_I);
      fault_d_d = (owner_q == OWN_D);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      holdoff_q    <= 1'b0;
      key_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      itlb_write_q <= 1'b0;
      dtlb_write_q <= 1'b0;
      tlb_key_q    <= '0;
      tlb_value_q  <= '0;
      fault_i_q    <= 1'b0;
      fault_d_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      holdoff_q    <= holdoff_d;
      key_q        <= key_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      itlb_write_q <= itlb_write_d;
      dtlb_write_q <= dtlb_write_d;
      tlb_key_q    <= tlb_key_d;
      tlb_value_q  <= tlb_value_d;
      fault_i_q    <= fault_i_d;
      fault_d_q    <= fault_d_d;
      busy_q       <= busy_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign itlb_write   = itlb_write_q;
  assign dtlb_write   = dtlb_write_q;
  assign tlb_key      = tlb_key_q;
  assign tlb_value    = tlb_value_q;
  assign fault_i      = fault_i_q;
  assign fault_d      = fault_d_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cpu_tlb_refill_ctrl.sv
// Scoreboard bench for cpu_tlb_refill_ctrl: expected refills/faults are queued when misses are driven.
module tb_cpu_tlb_refill_ctrl;

  typedef struct packed {
    logic        side;   // 0 = I, 1 = D
    logic        fault;
    logic [15:0] key;
    logic [15:0] value;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        itlb_miss, dtlb_miss;
  logic [15:0] itlb_key, dtlb_key;
  logic [31:0] ptbr;
  logic        itlb_write, dtlb_write, fault_i, fault_d, busy;
  logic [15:0] tlb_key, tlb_value;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   gap;

  cpu_tlb_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

  cpu_tlb_refill_ctrl #(
    .KEY_WIDTH(16), .VALUE_WIDTH(16), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .itlb_miss  (itlb_miss),
    .itlb_key   (itlb_key),
    .dtlb_miss  (dtlb_miss),
    .dtlb_key   (dtlb_key),
    .ptbr       (ptbr),
    .mem        (mif),
    .itlb_write (itlb_write),
    .dtlb_write (dtlb_write),
    .tlb_key    (tlb_key),
    .tlb_value  (tlb_value),
    .fault_i    (fault_i),
    .fault_d    (fault_d),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic side, input logic fault, input logic [15:0] key,
                      input logic [15:0] value);
    exp_t e;
    e.side = side; e.fault = fault; e.key = key; e.value = value;
    sb.push_back(e);
  endtask

  // Waits (bounded) on falling edges until the DUT raises mem_req.
  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!mif.mem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_req"}, mif.mem_req, 1);
  endtask

  // Memory slave: holds ready low rdy_dly cycles, optionally with a junk rvalid in REQ,
  // then accepts and returns rdata the following cycle. Returns at the FILL-cycle falling edge.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input int rdy_dly,
                       input bit spur, input logic [31:0] rdata);
    check({tag, "_addr"}, mif.mem_addr, exp_addr);
    if (spur) begin
      mif.mem_rvalid = 1'b1;
      mif.mem_rdata  = 32'h8000_0EEE;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clock);
      check({tag, "_req_hold"}, mif.mem_req, 1);
      check({tag, "_addr_hold"}, mif.mem_addr, exp_addr);
    end
    mif.mem_ready = 1'b1;
    @(negedge clock);
    mif.mem_ready  = 1'b0;
    check({tag, "_req_drop"}, mif.mem_req, 0);
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = rdata;
    @(negedge clock);
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
  endtask

  always @(negedge clock) begin
    if (itlb_write || dtlb_write || fault_i || fault_d) begin
      check("excl", (itlb_write & dtlb_write) | ((itlb_write | dtlb_write) & (fault_i | fault_d)) |
                    (fault_i & fault_d), 0);
      if (sb.size() == 0) begin
        check("sb_unexpected", {itlb_write, dtlb_write, fault_i, fault_d}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_side", dtlb_write | fault_d, mon_e.side);
        check("sb_kind", fault_i | fault_d, mon_e.fault);
        if (!mon_e.fault) begin
          check("sb_key", tlb_key, mon_e.key);
          check("sb_value", tlb_value, mon_e.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    itlb_miss = 1'b0; dtlb_miss = 1'b0;
    itlb_key = '0; dtlb_key = '0;
    ptbr = 32'h1000;
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_req", mif.mem_req, 0);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_strobes", {itlb_write, dtlb_write, fault_i, fault_d}, 0);
    check("rst_keyval", {tlb_key, tlb_value}, 0);
    reset = 1'b1;
    @(negedge clock);

    // I-only miss, with a junk rvalid alongside ready in the REQ cycle
    itlb_key = 16'h10; itlb_miss = 1'b1;
    push(1'b0, 1'b0, 16'h10, 16'h20);
    wait_req("t1", gap);
    check("t1_grant_gap", gap, 1);
    itlb_miss = 1'b0;
    check("t1_busy", busy, 1);
    serve("t1", 32'h1040, 0, 1'b1, 32'h8000_0020);
    check("t1_write", itlb_write, 1);
    check("t1_nofault", fault_i, 0);
    repeat (2) @(negedge clock);

    // Tie after reset: D first, then I after the settle cycle
    dtlb_key = 16'h11; itlb_key = 16'h12;
    dtlb_miss = 1'b1; itlb_miss = 1'b1;
    push(1'b1, 1'b0, 16'h11, 16'h31);
    push(1'b0, 1'b0, 16'h12, 16'h32);
    wait_req("t2d", gap);
    dtlb_miss = 1'b0;
    serve("t2d", 32'h1044, 0, 1'b0, 32'h8000_0031);
    check("t2d_write", dtlb_write, 1);
    wait_req("t2i", gap);
    check("t2_regrant_gap", gap, 3);
    itlb_miss = 1'b0;
    serve("t2i", 32'h1048, 0, 1'b0, 32'h8000_0032);
    check("t2i_write", itlb_write, 1);
    repeat (2) @(negedge clock);

    // Invalid PTE on D: fault pulse, no write, busy drops next cycle
    dtlb_key = 16'h13; dtlb_miss = 1'b1;
    push(1'b1, 1'b1, 16'h13, 16'h0);
    wait_req("t3", gap);
    dtlb_miss = 1'b0;
    serve("t3", 32'h104C, 0, 1'b0, 32'h0000_0022);
    check("t3_fault", fault_d, 1);
    check("t3_busy_fill", busy, 1);
    @(negedge clock);
    check("t3_fault_pulse", fault_d, 0);
    check("t3_busy_drop", busy, 0);
    @(negedge clock);

    // Slow mem_ready, spurious rvalid in REQ, key changes mid-walk
    itlb_key = 16'h14; itlb_miss = 1'b1;
    push(1'b0, 1'b0, 16'h14, 16'h0ABC);
    wait_req("t4", gap);
    itlb_miss = 1'b0;
    itlb_key = 16'h7777;
    serve("t4", 32'h1050, 5, 1'b1, 32'h8000_0ABC);
    check("t4_write", itlb_write, 1);
    repeat (2) @(negedge clock);

    // Reset while waiting for data; the late response must be dropped
    dtlb_key = 16'h15; dtlb_miss = 1'b1;
    wait_req("t5", gap);
    dtlb_miss = 1'b0;
    check("t5_addr", mif.mem_addr, 32'h1054);
    mif.mem_ready = 1'b1;
    @(negedge clock);
    mif.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_req", mif.mem_req, 0);
    check("t5_rst_addr", mif.mem_addr, 0);
    @(negedge clock);
    reset = 1'b1;
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h8000_0055;
    @(negedge clock);
    mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    check("t5_idle", busy, 0);
    @(negedge clock);
    itlb_key = 16'h16; itlb_miss = 1'b1;
    push(1'b0, 1'b0, 16'h16, 16'h33);
    wait_req("t5b", gap);
    itlb_miss = 1'b0;
    serve("t5b", 32'h1058, 0, 1'b0, 32'h8000_0033);
    check("t5b_write", itlb_write, 1);
    repeat (2) @(negedge clock);

`ifdef CPU_TLB_WALK_TIMEOUT_EN
    // No response: fault after 8 cycles in REQ/WAIT, late rvalid ignored
    itlb_key = 16'h17; itlb_miss = 1'b1;
    push(1'b0, 1'b1, 16'h17, 16'h0);
    wait_req("t6", gap);
    itlb_miss = 1'b0;
    check("t6_addr", mif.mem_addr, 32'h105C);
    mif.mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      mif.mem_ready = 1'b0;
      if (i < 8) check("t6_no_early_fault", fault_i, 0);
    end
    check("t6_fault", fault_i, 1);
    check("t6_busy", busy, 0);
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h8000_0066;
    @(negedge clock);
    mif.mem_rvalid = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_late_nowrite", {itlb_write, dtlb_write}, 0);
`endif

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
